// File: rtl/mem_dump_reader_pkg.sv
// Shared definitions for the memory-dump reader: default bus widths and FSM state encoding.
// Memory is word-addressed; the .data segment begins at word 2048 of 4096.
package mem_dump_reader_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } dump_state_t;

endpackage

// File: rtl/mem_dump_reader_skid_fifo2.sv
// Two-entry FIFO: head is visible combinationally, no added latency.
// Push is dropped only when full with no pop; push+pop is legal at any occupancy.
module skid_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] pop_data_o,
    output logic         full_o,
    output logic         empty_o
);

    logic [W-1:0] slot_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   cnt_q;
    logic         do_push;
    logic         do_pop;

    assign empty_o    = (cnt_q == 2'd0);
    assign full_o     = (cnt_q == 2'd2);
    assign do_pop     = pop_i && !empty_o;
    // When full, the slot being written is the head leaving this same cycle.
    assign do_push    = push_i && (!full_o || do_pop);
    assign pop_data_o = slot_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                slot_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/mem_dump_reader.sv
// Streams count words starting at base_addr out of a 1-cycle-latency memory.
// First word valid 2 edges after start; stalls on out_ready, never more than 2 reads ahead.
module mem_dump_reader
    import mem_dump_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last
);

    localparam int FW = DATA_W + ADDR_W + 1;

    dump_state_t       state_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W:0]   rd_left_q;
    logic              infl_q;
    logic [ADDR_W-1:0] infl_addr_q;
    logic              infl_last_q;
    logic              zero_done_q;

    logic [FW-1:0]     head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [1:0]        fifo_occ;
    logic [1:0]        occ;
    logic              pop;
    logic              issue;
    logic              issue_last;
    logic              head_last;

    skid_fifo2 #(.W(FW)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (infl_q),
        .push_data_i ({infl_last_q, infl_addr_q, mem_rdata}),
        .pop_i       (pop),
        .pop_data_o  (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign fifo_occ   = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
    assign occ        = fifo_occ + {1'b0, infl_q};
    assign pop        = out_valid && out_ready;
    assign head_last  = head[FW-1];
    // A word leaving this cycle frees the slot the new read will land in.
    assign issue      = (state_q == ST_READ) && (rd_left_q != '0) &&
                        ((occ < 2'd2) || ((occ == 2'd2) && pop));
    assign issue_last = issue && (rd_left_q == (ADDR_W+1)'(1));

    assign busy      = (state_q != ST_IDLE);
    assign done      = zero_done_q || (pop && head_last);
    assign mem_ren   = issue;
    assign mem_addr  = rd_addr_q;
    assign out_valid = !fifo_empty;
    assign out_data  = head[DATA_W-1:0];
    assign out_addr  = head[DATA_W +: ADDR_W];
    assign out_last  = out_valid && head_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rd_addr_q   <= '0;
            rd_left_q   <= '0;
            infl_q      <= 1'b0;
            infl_addr_q <= '0;
            infl_last_q <= 1'b0;
            zero_done_q <= 1'b0;
        end else begin
            zero_done_q <= 1'b0;
            infl_q      <= issue;
            infl_addr_q <= rd_addr_q;
            infl_last_q <= issue_last;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (count == '0) begin
                            zero_done_q <= 1'b1;
                        end else begin
                            rd_addr_q <= base_addr;
                            rd_left_q <= count;
                            state_q   <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        rd_addr_q <= rd_addr_q + ADDR_W'(1);
                        rd_left_q <= rd_left_q - (ADDR_W+1)'(1);
                        if (issue_last) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop && head_last) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dump_reader.sv
// Scoreboard bench for mem_dump_reader against a word-addressed 1-cycle-latency memory.
module tb_mem_dump_reader;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int NW = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   count;
    logic          busy, done, mem_ren, out_valid, out_ready, out_last;
    logic [AW-1:0] mem_addr, out_addr;
    logic [DW-1:0] mem_rdata, out_data;

    mem_dump_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .mem_ren   (mem_ren),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [NW];
    always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_addr];

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   words_seen = 0;
    int   outstanding = 0;
    bit   ren_seen, vld_seen;
    int   rmode = 0;
    int   ph = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // out_ready driver: mode 0 always ready, mode 1 pattern 1,0,0 repeating
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rmode == 1) begin
                out_ready = (ph == 0);
                ph = (ph + 1) % 3;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    logic          stall_pend = 1'b0;
    logic [DW-1:0] hd;
    logic [AW-1:0] ha;
    logic          hl;

    always @(negedge clk) begin
        if (reset) begin
            outstanding = 0;
            stall_pend  = 1'b0;
        end else begin
            if (stall_pend) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, hd);
                chk("hold_addr", out_addr, ha);
                chk("hold_last", out_last, hl);
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_word", out_valid, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("data", out_data, e.d);
                    chk("addr", out_addr, e.a);
                    chk("last", out_last, e.l);
                    chk("done_with_last", done, e.l);
                end
                words_seen++;
            end
            outstanding = outstanding + int'(mem_ren) - int'(out_valid && out_ready);
            if (mem_ren) chk("reads_ahead_le2", (outstanding <= 2), 1);
            stall_pend = out_valid && !out_ready;
            hd = out_data; ha = out_addr; hl = out_last;
            if (mem_ren) ren_seen = 1'b1;
            if (out_valid) vld_seen = 1'b1;
        end
    end

    task automatic do_start(input int b, input int c);
        @(posedge clk); #1;
        base_addr = AW'(b);
        count     = (AW+1)'(c);
        start     = 1'b1;
        for (int i = 0; i < c; i++) begin
            exp_t e;
            e.a = AW'((b + i) % NW);
            e.d = mem[(b + i) % NW];
            e.l = (i == c - 1);
            sbq.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        do begin
            @(negedge clk); #1;
            k++;
        end while ((sbq.size() != 0 || busy) && k < 300);
        chk({tag, "_complete"}, (k < 300), 1);
    endtask

    initial begin
        int ws0, k;
        reset = 1'b1; start = 1'b0; base_addr = '0; count = '0;
        for (int i = 0; i < NW; i++) mem[i] = 32'h5A00_0000 + 32'(i * 7);
        mem[2048] = 11; mem[2049] = 22; mem[2050] = 33; mem[2051] = 44;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ren", mem_ren, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);

        // basic dump, ready held high: latency and one word per cycle
        rmode = 0;
        do_start(2048, 4);
        @(negedge clk);
        chk("t1_busy", busy, 1);
        chk("t1_ren", mem_ren, 1);
        chk("t1_ren_addr", mem_addr, 2048);
        chk("t1_valid_e0", out_valid, 0);
        @(negedge clk);
        chk("t1_valid_e1", out_valid, 0);
        @(negedge clk);
        chk("t1_valid_e2", out_valid, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t1_back_to_back", out_valid, 1);
        end
        @(negedge clk);
        chk("t1_idle_after", busy, 0);
        wait_idle("t1");

        // toggling ready
        rmode = 1; ph = 0;
        do_start(2048, 4);
        wait_idle("t2");
        rmode = 0;

        // wrap past the top word
        do_start(4094, 4);
        wait_idle("t3");

        // zero-length dump
        ren_seen = 1'b0; vld_seen = 1'b0;
        do_start(2048, 0);
        @(negedge clk);
        chk("t4_done", done, 1);
        chk("t4_busy", busy, 0);
        @(negedge clk);
        chk("t4_done_pulse", done, 0);
        repeat (3) @(negedge clk);
        chk("t4_no_ren", ren_seen, 0);
        chk("t4_no_valid", vld_seen, 0);

        // reset mid-dump, then a fresh short dump
        ws0 = words_seen;
        do_start(2048, 8);
        k = 0;
        while (words_seen < ws0 + 2 && k < 100) begin
            @(negedge clk); #1;
            k++;
        end
        chk("t5_two_words", (words_seen >= ws0 + 2), 1);
        @(posedge clk); #1;
        reset = 1'b1;
        sbq.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t5_busy_after_rst", busy, 0);
        chk("t5_valid_after_rst", out_valid, 0);
        ws0 = words_seen;
        do_start(2048, 2);
        wait_idle("t5");
        chk("t5_word_count", words_seen - ws0, 2);

        // start while busy must be ignored
        rmode = 1; ph = 0;
        do_start(2048, 4);
        repeat (2) @(posedge clk);
        #1;
        base_addr = 100; count = 3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle("t6");
        rmode = 0;
        vld_seen = 1'b0;
        repeat (6) @(negedge clk);
        chk("t6_no_extra", vld_seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_dump_reader.md
MEM_DUMP_READER -- requirements
Module: mem_dump_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 32: memory word width.
REQ-002 SHALL have parameter ADDR_W, default 12: word-address width (4096 words; .data segment starts at word 2048).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a dump.
REQ-006 SHALL have port base_addr  input  ADDR_W  first word address, sampled on an accepted start.
REQ-007 SHALL have port count  input  ADDR_W+1  number of words to read, sampled on an accepted start.
REQ-008 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse when the last word is accepted downstream.
REQ-010 SHALL have port mem_ren  output  1  memory read strobe.
REQ-011 SHALL have port mem_addr  output  ADDR_W  memory word address.
REQ-012 SHALL have port mem_rdata  input  DATA_W  read data, valid exactly one cycle after mem_ren.
REQ-013 SHALL have port out_valid  output  1  stream word available.
REQ-014 SHALL have port out_ready  input  1  downstream accepts the word.
REQ-015 SHALL have port out_data  output  DATA_W  word value.
REQ-016 SHALL have port out_addr  output  ADDR_W  word address of out_data.
REQ-017 SHALL have port out_last  output  1  high with the final word of a dump.

Function
REQ-018 SHALL implement FSM IDLE -> READ -> DRAIN -> IDLE.
REQ-019 IDLE: start=1 SHALL latch base_addr/count; count=0 SHALL pulse done next cycle with no read issued and stay IDLE; otherwise go to READ.
REQ-020 start SHALL be ignored while busy=1.
REQ-021 READ: SHALL issue one read per cycle (mem_ren=1) when (buffered + in-flight words) < 2, or when = 2 and an out handshake occurs that cycle.
REQ-022 Read i SHALL use address (base_addr + i) mod 2^ADDR_W; wrap-around past the top word is legal.
REQ-023 After the count-th read issues, SHALL go to DRAIN; DRAIN SHALL go to IDLE in the cycle the last word handshakes, asserting done for that one cycle.
REQ-024 Returned data SHALL enter a 2-entry FIFO together with its address; FIFO head drives out_data/out_addr/out_valid.
REQ-025 A word SHALL transfer only when out_valid && out_ready; out_data/out_addr/out_last SHALL hold stable while out_valid && !out_ready.
REQ-026 Words SHALL be emitted in increasing address order with no loss or duplication; out_last=1 only on word count-1.
REQ-027 With out_ready held high, throughput SHALL be one word per cycle; first out_valid two cycles after the accepted start.
REQ-028 Simultaneous FIFO push and pop SHALL be legal at any occupancy including full.
REQ-029 mem_ren SHALL be 0 outside READ; mem_addr is don't-care when mem_ren=0.

Reset
REQ-030 reset SHALL force IDLE, busy=0, done=0, mem_ren=0, out_valid=0, out_last=0, FIFO empty, counters 0, taking priority over start and mem_rdata.
REQ-031 reset mid-dump SHALL abort; data from a read issued in the reset cycle SHALL be discarded.

Structure
REQ-032 FSM state encoding and default DATA_W/ADDR_W SHALL live in the shared CPU package/include used by the memory and SCPU.
REQ-033 The 2-entry buffer SHALL be a sub-module named skid_fifo2 (parameterised width, push/pop/full/empty).
REQ-034 SHALL connect to the same word-addressed memory model the SCPU uses, via a second read port or a bench-controlled mux.

Verification
REQ-035 mem[2048..2051]=11,22,33,44; start, base=2048, count=4, out_ready=1 -> words 11,22,33,44 on 4 consecutive cycles, addrs 2048..2051, out_last on 44, done on same cycle.
REQ-036 Same load, out_ready toggling 1,0,0,1,... -> identical sequence, outputs stable during stalls, at most 2 reads ahead of the stream.
REQ-037 base=4094, count=4 -> addrs 4094,4095,0,1 with matching data.
REQ-038 count=0 -> done one cycle later, mem_ren never asserted, out_valid never asserted.
REQ-039 reset asserted after second word of a count=8 dump -> next cycle busy=0, out_valid=0; following start with count=2 yields exactly 2 correct words.
REQ-040 start pulsed while busy with different base -> ignored; original dump completes unchanged.
